// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver: FSM encodings and frame bit values.
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    // Odd parity holds when the data bits plus parity bit contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 line, with a fall flag.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic ck,
    input  logic reset,
    input  logic pin,
    output logic filt,
    output logic fall
);

    logic       sync1_q, sync2_q;
    logic       filt_q, filt_d;
    logic       fall_q, fall_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    // Idle-high bus: everything resets to 1 so reset release never looks like an edge.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt = filt_q;
    assign fall = fall_q;

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: de-frames 11-bit frames and assembles PKT_BYTES-byte packets.
module ps2_packet_rx
    import ps2_pkg::*;
#(
    parameter int unsigned PKT_BYTES   = 3,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 3400
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   err_parity,
    output logic                   err_frame,
    output logic                   err_timeout,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic clk_filt, clk_fall;
    logic data_filt, data_fall;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .ck   (ck),
        .reset(reset),
        .pin  (ps2_clk),
        .filt (clk_filt),
        .fall (clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_data_filter (
        .ck   (ck),
        .reset(reset),
        .pin  (ps2_data),
        .filt (data_filt),
        .fall (data_fall)
    );

    ps2_state_t             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_ok_q, par_ok_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [8*PKT_BYTES-1:0] asm_q, asm_d;
    logic [8*PKT_BYTES-1:0] pkt_data_q, pkt_data_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic                   err_par_q, err_par_d;
    logic                   err_frm_q, err_frm_d;
    logic                   err_to_q, err_to_d;
    logic                   ovf_q, ovf_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [8*PKT_BYTES-1:0] pkt_next;
    logic                   last_byte;
    logic                   complete;
    logic                   timeout;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        err_par_d   = 1'b0;
        err_frm_d   = 1'b0;
        err_to_d    = 1'b0;
        ovf_d       = 1'b0;
        to_cnt_d    = to_cnt_q;
        complete    = 1'b0;

        // Packet as it would look with the byte in the shifter placed at the current index.
        pkt_next = asm_q;
        for (int b = 0; b < PKT_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                pkt_next[b*8 +: 8] = shift_q;
            end
        end
        last_byte = (idx_q == IDX_W'(PKT_BYTES - 1));

        if (pkt_valid_q && pkt_ready) begin
            pkt_valid_d = 1'b0;
        end

        timeout = (to_cnt_q == TO_W'(TIMEOUT_CYC));

        if (timeout) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
            idx_d    = '0;
            to_cnt_d = '0;
        end else begin
            if (clk_fall || (state_q == ST_IDLE && idx_q == '0)) begin
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end

            if (clk_fall) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (data_filt == START_BIT) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            err_frm_d = 1'b1;
                            idx_d     = '0;
                        end
                    end
                    ST_DATA: begin
                        shift_d   = {data_filt, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            state_d = ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_ok_d = parity_ok(shift_q, data_filt);
                        state_d  = ST_STOP;
                    end
                    ST_STOP: begin
                        state_d = ST_IDLE;
                        // A bad stop bit takes precedence over a parity failure.
                        if (data_filt != STOP_BIT) begin
                            err_frm_d = 1'b1;
                            idx_d     = '0;
                        end else if (!par_ok_q) begin
                            err_par_d = 1'b1;
                            idx_d     = '0;
                        end else begin
                            asm_d = pkt_next;
                            if (last_byte) begin
                                complete = 1'b1;
                                idx_d    = '0;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                    end
                endcase
            end
        end

        // A same-cycle handshake frees the output register for the new packet.
        if (complete) begin
            if (!pkt_valid_q || pkt_ready) begin
                pkt_data_d  = pkt_next;
                pkt_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            idx_q       <= '0;
            asm_q       <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_to_q    <= 1'b0;
            ovf_q       <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_to_q    <= err_to_d;
            ovf_q       <= ovf_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign pkt_data    = pkt_data_q;
    assign pkt_valid   = pkt_valid_q;
    assign err_parity  = err_par_q;
    assign err_frame   = err_frm_q;
    assign err_timeout = err_to_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q != ST_IDLE) || (idx_q != '0);

    // The data line only matters at clock falls.
    logic unused_filt;
    assign unused_filt = data_fall ^ clk_filt;

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Directed bench for ps2_packet_rx: 3-byte and 1-byte instances driven from shared PS/2 pins.
module tb_ps2_packet_rx;

    localparam int H = 16;  // half PS/2 clock period in ck cycles

    logic        ck = 1'b0;
    logic        reset;
    logic        ps2_clk, ps2_data;
    logic        pkt_ready;
    logic        ready_one = 1'b1;

    logic [23:0] pkt_data3;
    logic        pkt_valid3, err_par3, err_frm3, err_to3, ovf3, busy3;
    logic [7:0]  pkt_data1;
    logic        pkt_valid1, err_par1, err_frm1, err_to1, ovf1, busy1;

    always #5 ck = ~ck;

    ps2_packet_rx #(
        .PKT_BYTES(3), .FILTER_LEN(4), .TIMEOUT_CYC(3400)
    ) dut3 (
        .ck(ck), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .pkt_data(pkt_data3), .pkt_valid(pkt_valid3), .pkt_ready(pkt_ready),
        .err_parity(err_par3), .err_frame(err_frm3), .err_timeout(err_to3),
        .overflow(ovf3), .busy(busy3)
    );

    ps2_packet_rx #(
        .PKT_BYTES(1), .FILTER_LEN(4), .TIMEOUT_CYC(3400)
    ) dut1 (
        .ck(ck), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .pkt_data(pkt_data1), .pkt_valid(pkt_valid1), .pkt_ready(ready_one),
        .err_parity(err_par1), .err_frame(err_frm1), .err_timeout(err_to1),
        .overflow(ovf1), .busy(busy1)
    );

    int n_tests = 0, n_fail = 0;
    int n_acc3 = 0, n_perr = 0, n_ferr = 0, n_to = 0, n_ovf = 0, n_acc1 = 0;
    logic [23:0] last3 = '0;
    logic [7:0]  last1 = '0;

    always @(negedge ck) begin
        if (pkt_valid3 && pkt_ready) begin
            n_acc3 = n_acc3 + 1;
            last3  = pkt_data3;
        end
        if (pkt_valid1) begin
            n_acc1 = n_acc1 + 1;
            last1  = pkt_data1;
        end
        if (err_par3) n_perr = n_perr + 1;
        if (err_frm3) n_ferr = n_ferr + 1;
        if (err_to3)  n_to   = n_to + 1;
        if (ovf3)     n_ovf  = n_ovf + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    // One PS/2 bit: data set while clk high, then a full low phase.
    task automatic clk_bit(input logic b, input bit glitch, input bit rdy_pulse);
        ps2_data = b;
        if (glitch) begin
            cyc(8);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(H - 11);
        end else begin
            cyc(H);
        end
        ps2_clk = 1'b0;
        if (rdy_pulse) begin
            // pkt_ready high only at the posedge where the filtered fall is consumed
            cyc(6);
            pkt_ready = 1'b1;
            cyc(1);
            pkt_ready = 1'b0;
            cyc(H - 7);
        end else begin
            cyc(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch, input bit rdy_pulse);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            clk_bit(bits[i], glitch && (i >= 1) && (i <= 8), rdy_pulse && (i == 10));
        end
        ps2_data = 1'b1;
        cyc(2 * H);
    endtask

    task automatic send_pkt(input logic [23:0] p, input int n, input logic [2:0] bad_par,
                            input logic [2:0] bad_stop, input bit glitch, input bit rdy_last);
        for (int i = 0; i < n; i++) begin
            send_frame(p[8*i +: 8], bad_par[i], bad_stop[i], 11, glitch,
                       rdy_last && (i == n - 1));
        end
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic [2:0]  bad_par;
        logic [2:0]  bad_stop;
        int          exp_acc;
        logic [23:0] exp_pkt;
        int          exp_perr;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int a0, p0, f0, t0, o0, b0;

        vecs[0] = '{24'hFF0108, 3, 3'b000, 3'b000, 1, 24'hFF0108, 0, 0};
        vecs[1] = '{24'h002211, 2, 3'b010, 3'b000, 0, 24'h0,      1, 0};
        vecs[2] = '{24'h000000, 3, 3'b000, 3'b000, 1, 24'h000000, 0, 0};
        vecs[3] = '{24'h563412, 3, 3'b000, 3'b000, 1, 24'h563412, 0, 0};
        vecs[4] = '{24'h000077, 1, 3'b000, 3'b001, 0, 24'h0,      0, 1};
        vecs[5] = '{24'h000077, 1, 3'b001, 3'b001, 0, 24'h0,      0, 1};

        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        pkt_ready = 1'b1;
        cyc(3);
        check("reset pkt_data", 32'(pkt_data3), 32'h0);
        check("reset pkt_valid", 32'(pkt_valid3), 32'h0);
        check("reset busy", 32'(busy3), 32'h0);
        check("reset errs", 32'({err_par3, err_frm3, err_to3, ovf3}), 32'h0);
        reset = 1'b0;
        cyc(5);

        for (int v = 0; v < 6; v++) begin
            a0 = n_acc3; p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
            send_pkt(vecs[v].bytes, vecs[v].n, vecs[v].bad_par, vecs[v].bad_stop, 1'b0, 1'b0);
            check($sformatf("v%0d accepted", v), n_acc3 - a0, vecs[v].exp_acc);
            check($sformatf("v%0d err_parity", v), n_perr - p0, vecs[v].exp_perr);
            check($sformatf("v%0d err_frame", v), n_ferr - f0, vecs[v].exp_ferr);
            check($sformatf("v%0d overflow", v), n_ovf - o0, 0);
            check($sformatf("v%0d busy", v), 32'(busy3), 32'h0);
            if (vecs[v].exp_acc != 0) check($sformatf("v%0d pkt_data", v), 32'(last3),
                                            32'(vecs[v].exp_pkt));
        end

        // Start bit of 1 in idle
        f0 = n_ferr;
        clk_bit(1'b1, 1'b0, 1'b0);
        cyc(2 * H);
        check("idle start=1 err_frame", n_ferr - f0, 1);
        check("idle start=1 busy", 32'(busy3), 32'h0);

        // Inactivity timeout after the 5th data bit of byte 0
        t0 = n_to; a0 = n_acc3;
        send_frame(8'h5A, 1'b0, 1'b0, 6, 1'b0, 1'b0);
        cyc(3300);
        check("timeout not early", n_to - t0, 0);
        check("busy before timeout", 32'(busy3), 32'h1);
        cyc(150);
        check("timeout pulse", n_to - t0, 1);
        check("busy after timeout", 32'(busy3), 32'h0);
        send_pkt(24'h654321, 3, 3'b000, 3'b000, 1'b0, 1'b0);
        check("post-timeout accepted", n_acc3 - a0, 1);
        check("post-timeout pkt", 32'(last3), 32'h654321);

        // Overflow while the consumer stalls, then a coincident handshake
        pkt_ready = 1'b0;
        a0 = n_acc3; o0 = n_ovf;
        send_pkt(24'h030201, 3, 3'b000, 3'b000, 1'b0, 1'b0);
        check("ovf p1 valid", 32'(pkt_valid3), 32'h1);
        check("ovf p1 data", 32'(pkt_data3), 32'h030201);
        send_pkt(24'h060504, 3, 3'b000, 3'b000, 1'b0, 1'b0);
        check("ovf p2 pulse", n_ovf - o0, 1);
        check("ovf p2 data kept", 32'(pkt_data3), 32'h030201);
        send_pkt(24'h090807, 3, 3'b000, 3'b000, 1'b0, 1'b1);
        check("ovf p3 no extra overflow", n_ovf - o0, 1);
        check("ovf p3 old accepted", n_acc3 - a0, 1);
        check("ovf p3 old data", 32'(last3), 32'h030201);
        check("ovf p3 valid", 32'(pkt_valid3), 32'h1);
        check("ovf p3 data", 32'(pkt_data3), 32'h090807);
        pkt_ready = 1'b1;
        cyc(2);
        check("ovf p3 drained", n_acc3 - a0, 2);
        check("ovf p3 drained data", 32'(last3), 32'h090807);

        // Short clock glitches during data bits
        a0 = n_acc3; p0 = n_perr; f0 = n_ferr;
        send_pkt(24'h3CC35A, 3, 3'b000, 3'b000, 1'b1, 1'b0);
        check("glitch accepted", n_acc3 - a0, 1);
        check("glitch pkt", 32'(last3), 32'h3CC35A);
        check("glitch errs", (n_perr - p0) + (n_ferr - f0), 0);

        // Async reset after the 4th data bit
        send_frame(8'h55, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        #3 reset = 1'b1;
        cyc(2);
        check("rst3 pkt_data", 32'(pkt_data3), 32'h0);
        check("rst3 valid/busy", 32'({pkt_valid3, busy3}), 32'h0);
        check("rst1 pkt_data", 32'(pkt_data1), 32'h0);
        check("rst1 valid/busy", 32'({pkt_valid1, busy1}), 32'h0);
        check("rst errs", 32'({err_par1, err_frm1, err_to1, ovf1}), 32'h0);
        reset = 1'b0;
        cyc(5);
        a0 = n_acc1; p0 = n_perr; f0 = n_ferr;
        send_frame(8'hAA, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        check("post-rst kbd accepted", n_acc1 - a0, 1);
        check("post-rst kbd data", 32'(pkt_data1), 32'hAA);
        check("post-rst 3-byte partial busy", 32'(busy3), 32'h1);
        check("post-rst errs", (n_perr - p0) + (n_ferr - f0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
